axi_lite_csr_bank: RTL

AXI_LITE_CSR_BANK -- requirements
Module: axi_lite_csr_bank

---
 rtl/axi_lite_csr_pkg.sv | 26 ++
 rtl/axi_lite_csr_bank_if.sv | 33 +++
 rtl/axi_lite_csr_decode.sv | 40 ++++
 rtl/axi_lite_csr_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_csr_pkg.sv
// Shared types and constants for the AXI-Lite CSR bank.
package axi_lite_csr_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        KIND_RW   = 2'd0,
        KIND_RO   = 2'd1,
        KIND_TRIG = 2'd2,
        KIND_NONE = 2'd3
    } csr_kind_t;

endpackage

// File: rtl/axi_lite_csr_bank_if.sv
// AXI-Lite bus bundle between a bus master and the CSR bank.
interface axi_lite_csr_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_csr_decode.sv
// Word-index decoder: maps an index to register kind and offset within that kind.
module axi_lite_csr_decode
    import axi_lite_csr_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int N_RW   = 2,
    parameter int N_RO   = 1
) (
    input  logic [ADDR_W-1:0] idx,
    output csr_kind_t         kind,
    output logic [ADDR_W-1:0] offset,
    output logic              valid
);
    localparam logic [ADDR_W-1:0] RO_BASE  = ADDR_W'(N_RW);
    localparam logic [ADDR_W-1:0] TRIG_IDX = ADDR_W'(N_RW + N_RO);

    // Classify the index into RW, RO, trigger or unmapped space.
    always_comb begin
        kind   = KIND_NONE;
        offset = {ADDR_W{1'b0}};
        valid  = 1'b0;
        if (idx < RO_BASE) begin
            kind   = KIND_RW;
            offset = idx;
            valid  = 1'b1;
        end else if (idx < TRIG_IDX) begin
            kind   = KIND_RO;
            offset = idx - RO_BASE;
            valid  = 1'b1;
        end else if (idx == TRIG_IDX) begin
            kind   = KIND_TRIG;
            offset = {ADDR_W{1'b0}};
            valid  = 1'b1;
        end else begin
            kind   = KIND_NONE;
            offset = {ADDR_W{1'b0}};
            valid  = 1'b0;
        end
    end
endmodule

// File: rtl/axi_lite_csr_bank.sv
// AXI-Lite CSR bank: RW registers, sampled RO status, and a trigger-pulse word.
// Write and read channels run as independent FSMs; reads see pre-commit values.
module axi_lite_csr_bank
    import axi_lite_csr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int N_RW   = 2,
    parameter int N_RO   = 1,
    parameter int N_TRIG = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    axi_lite_csr_bank_if.slave            cbus,
    output logic [N_RW-1:0][DATA_W-1:0]   csr_rw,
    input  logic [N_RO-1:0][DATA_W-1:0]   csr_ro,
    output logic [N_TRIG-1:0]             csr_trig,
    input  logic [N_TRIG-1:0]             csr_trig_stat
);
    localparam int STRB_W = DATA_W / 8;

    wr_state_t           wr_state_r;
    logic                aw_held_r;
    logic                w_held_r;
    logic [ADDR_W-1:0]   awaddr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic                awready_r;
    logic                wready_r;
    logic                bvalid_r;
    resp_t               bresp_r;

    rd_state_t           rd_state_r;
    logic                arready_r;
    logic                rvalid_r;
    resp_t               rresp_r;
    logic [DATA_W-1:0]   rdata_r;

    csr_kind_t           wr_kind_s;
    logic [ADDR_W-1:0]   wr_off_s;
    logic                wr_valid_s;
    csr_kind_t           rd_kind_s;
    logic [ADDR_W-1:0]   rd_off_s;
    logic                rd_valid_s;
    logic [DATA_W-1:0]   wmask_s;
    logic                wr_err_s;
    logic [DATA_W-1:0]   rd_data_s;
    resp_t               rd_resp_s;

    axi_lite_csr_decode #(.ADDR_W(ADDR_W), .N_RW(N_RW), .N_RO(N_RO)) u_wr_decode (
        .idx    (awaddr_r),
        .kind   (wr_kind_s),
        .offset (wr_off_s),
        .valid  (wr_valid_s)
    );

    axi_lite_csr_decode #(.ADDR_W(ADDR_W), .N_RW(N_RW), .N_RO(N_RO)) u_rd_decode (
        .idx    (cbus.araddr),
        .kind   (rd_kind_s),
        .offset (rd_off_s),
        .valid  (rd_valid_s)
    );

    assign cbus.awready = awready_r;
    assign cbus.wready  = wready_r;
    assign cbus.bvalid  = bvalid_r;
    assign cbus.bresp   = bresp_r;
    assign cbus.arready = arready_r;
    assign cbus.rvalid  = rvalid_r;
    assign cbus.rresp   = rresp_r;
    assign cbus.rdata   = rdata_r;

    // Expand the held byte strobes into a bit mask.
    always_comb begin
        wmask_s = {DATA_W{1'b0}};
        for (int i = 0; i < STRB_W; i++) begin
            wmask_s[i*8 +: 8] = {8{wstrb_r[i]}};
        end
    end

    // Only RW and trigger targets accept writes; everything else errors.
    always_comb begin
        wr_err_s = 1'b1;
        if (wr_valid_s && ((wr_kind_s == KIND_RW) || (wr_kind_s == KIND_TRIG))) begin
            wr_err_s = 1'b0;
        end else begin
            wr_err_s = 1'b1;
        end
    end

    // Read data/response mux for the address currently on the AR channel.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        rd_resp_s = OKAY;
        case (rd_kind_s)
            KIND_RW: begin
                for (int i = 0; i < N_RW; i++) begin
                    if (rd_off_s == ADDR_W'(i)) begin
                        rd_data_s = csr_rw[i];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
            KIND_RO: begin
                for (int i = 0; i < N_RO; i++) begin
                    if (rd_off_s == ADDR_W'(i)) begin
                        rd_data_s = csr_ro[i];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
            KIND_TRIG: begin
                rd_data_s = DATA_W'(csr_trig_stat);
            end
            default: begin
                rd_data_s = {DATA_W{1'b0}};
                rd_resp_s = SLVERR;
            end
        endcase
        if (!rd_valid_s) begin
            rd_resp_s = SLVERR;
        end else begin
            rd_resp_s = rd_resp_s;
        end
    end

    // Write FSM: collect AW and W independently, commit, then hold B until accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_r <= W_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awaddr_r   <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wstrb_r    <= {STRB_W{1'b0}};
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= OKAY;
            csr_rw     <= {(N_RW*DATA_W){1'b0}};
            csr_trig   <= {N_TRIG{1'b0}};
        end else begin
            csr_trig <= {N_TRIG{1'b0}};
            case (wr_state_r)
                W_IDLE: begin
                    if (aw_held_r && w_held_r) begin
                        if (!wr_err_s && (wr_kind_s == KIND_RW)) begin
                            for (int i = 0; i < N_RW; i++) begin
                                if (wr_off_s == ADDR_W'(i)) begin
                                    csr_rw[i] <= (csr_rw[i] & ~wmask_s) | (wdata_r & wmask_s);
                                end
                            end
                        end else if (!wr_err_s && (wr_kind_s == KIND_TRIG)) begin
                            csr_trig <= wdata_r[N_TRIG-1:0] & wmask_s[N_TRIG-1:0];
                        end
                        bresp_r    <= wr_err_s ? SLVERR : OKAY;
                        bvalid_r   <= 1'b1;
                        aw_held_r  <= 1'b0;
                        w_held_r   <= 1'b0;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b0;
                        wr_state_r <= W_RESP;
                    end else begin
                        if (cbus.awvalid && awready_r) begin
                            aw_held_r <= 1'b1;
                            awaddr_r  <= cbus.awaddr;
                            awready_r <= 1'b0;
                        end else begin
                            awready_r <= ~aw_held_r;
                        end
                        if (cbus.wvalid && wready_r) begin
                            w_held_r <= 1'b1;
                            wdata_r  <= cbus.wdata;
                            wstrb_r  <= cbus.wstrb;
                            wready_r <= 1'b0;
                        end else begin
                            wready_r <= ~w_held_r;
                        end
                    end
                end
                W_RESP: begin
                    if (cbus.bready) begin
                        bvalid_r   <= 1'b0;
                        awready_r  <= 1'b1;
                        wready_r   <= 1'b1;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    aw_held_r  <= 1'b0;
                    w_held_r   <= 1'b0;
                    bvalid_r   <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: accept an address, present data until accepted, then re-arm.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rresp_r    <= OKAY;
            rdata_r    <= {DATA_W{1'b0}};
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (cbus.arvalid && arready_r) begin
                        rdata_r    <= rd_data_s;
                        rresp_r    <= rd_resp_s;
                        rvalid_r   <= 1'b1;
                        arready_r  <= 1'b0;
                        rd_state_r <= R_DATA;
                    end else begin
                        arready_r  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (cbus.rready) begin
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    rvalid_r   <= 1'b0;
                    arready_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
